// File: rtl/mux_n_rr_if.sv
// Stream bundle between NUM_IN producers, the mux and one consumer.
// The slave modport is the mux side; the master modport is the producers/consumer side.
interface mux_n_rr_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 3
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_last;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_ready;
  logic                    out_valid;
  logic                    out_last;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_ready;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, out_sel
  );
endinterface

// File: rtl/mux_n_rr.sv
// N-input registered stream mux with round-robin or fixed-priority arbitration.
// A source that starts a packet owns the output until its last beat transfers.
module mux_n_rr #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned MODE   = 0
) (
  input logic        clk,
  input logic        rst,
  mux_n_rr_if.slave  bus
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q;
  logic [SEL_W-1:0] owner_q;
  logic [SEL_W-1:0] ptr_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_sel_q;

  logic             load;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] cand_sel;
  int               cand;
  logic             xfer;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] nxt_ptr;
  logic [NUM_IN-1:0] in_ready_c;

  assign load = !out_valid_q || bus.out_ready;

  // Arbiter: owner only while locked, else priority scan from ptr (RR) or from 0 (fixed).
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_sel = '0;
    if (state_q == LOCKED) begin
      gnt_any = bus.in_valid[owner_q];
      gnt_idx = owner_q;
    end else if (MODE == 1) begin
      for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
        if (bus.in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Descending scan so the candidate closest to ptr is the final winner.
      for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
        cand = int'(ptr_q) + k;
        if (cand >= int'(NUM_IN)) cand = cand - int'(NUM_IN);
        cand_sel = SEL_W'(cand);
        if (bus.in_valid[cand_sel]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_sel;
        end
      end
    end
  end

  assign xfer = gnt_any && load && !rst;

  always_comb begin
    in_ready_c = '0;
    if (xfer) in_ready_c[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (gnt_idx == SEL_W'(i)) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign sel_last = bus.in_last[gnt_idx];
  assign nxt_ptr  = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + 1'b1;

  // Packet-lock state machine together with the output pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_last_q  <= sel_last;
        out_data_q  <= sel_data;
        out_sel_q   <= gnt_idx;
      end else if (load) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (sel_last) begin
              ptr_q <= nxt_ptr;
            end else begin
              state_q <= LOCKED;
              owner_q <= gnt_idx;
            end
          end
        end
        LOCKED: begin
          if (xfer && sel_last) begin
            state_q <= IDLE;
            ptr_q   <= nxt_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_n_rr.sv
// Directed bench for mux_n_rr: one round-robin and one fixed-priority instance
// share the same stimulus; vectors hold inputs plus expected pre-edge outputs.
module tb_mux_n_rr;
  logic        clk;
  logic        rst;
  logic [2:0]  v;
  logic [2:0]  l;
  logic [23:0] d;
  logic        ordy;

  int n_tests = 0;
  int n_fail  = 0;

  mux_n_rr_if #(.WIDTH(8), .NUM_IN(3)) if_rr ();
  mux_n_rr_if #(.WIDTH(8), .NUM_IN(3)) if_fp ();

  assign if_rr.in_valid  = v;
  assign if_rr.in_last   = l;
  assign if_rr.in_data   = d;
  assign if_rr.out_ready = ordy;
  assign if_fp.in_valid  = v;
  assign if_fp.in_last   = l;
  assign if_fp.in_data   = d;
  assign if_fp.out_ready = ordy;

  mux_n_rr #(.WIDTH(8), .NUM_IN(3), .MODE(0)) dut_rr (.clk(clk), .rst(rst), .bus(if_rr.slave));
  mux_n_rr #(.WIDTH(8), .NUM_IN(3), .MODE(1)) dut_fp (.clk(clk), .rst(rst), .bus(if_fp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [2:0]  l;
    logic [23:0] d;
    logic        ordy;
    logic [2:0]  rdy;
    logic        ov;
    logic        ol;
    logic [1:0]  sel;
    logic [7:0]  od;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [2:0] vv, input logic [2:0] ll,
                              input logic [23:0] dd, input logic o, input logic [2:0] rdy,
                              input logic ov, input logic ol, input logic [1:0] sel,
                              input logic [7:0] od);
    vec_t t;
    t.rst = r; t.v = vv; t.l = ll; t.d = dd; t.ordy = o;
    t.rdy = rdy; t.ov = ov; t.ol = ol; t.sel = sel; t.od = od;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] fv[6];
    logic [2:0] frdy[6];
    logic [1:0] fsel[6];
    logic       fov[6];

    // reset, round-robin fairness, idle drain
    vecs.push_back(mk(1, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b000, 0, 0, 2'd0, 8'h00));
    vecs.push_back(mk(0, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b001, 0, 0, 2'd0, 8'h00));
    vecs.push_back(mk(0, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b010, 1, 1, 2'd0, 8'hA0));
    vecs.push_back(mk(0, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b100, 1, 1, 2'd1, 8'hB1));
    vecs.push_back(mk(0, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b001, 1, 1, 2'd2, 8'hC2));
    vecs.push_back(mk(0, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b010, 1, 1, 2'd0, 8'hA0));
    vecs.push_back(mk(0, 3'b111, 3'b111, 24'hC2B1A0, 1, 3'b100, 1, 1, 2'd1, 8'hB1));
    vecs.push_back(mk(0, 3'b000, 3'b111, 24'hC2B1A0, 1, 3'b000, 1, 1, 2'd2, 8'hC2));
    vecs.push_back(mk(0, 3'b000, 3'b111, 24'hC2B1A0, 1, 3'b000, 0, 1, 2'd2, 8'hC2));
    // backpressure on 0xA5
    vecs.push_back(mk(0, 3'b001, 3'b001, 24'hC2B1A5, 1, 3'b001, 0, 1, 2'd2, 8'hC2));
    vecs.push_back(mk(0, 3'b010, 3'b010, 24'hC2B1A5, 0, 3'b000, 1, 1, 2'd0, 8'hA5));
    vecs.push_back(mk(0, 3'b010, 3'b010, 24'hC2B1A5, 0, 3'b000, 1, 1, 2'd0, 8'hA5));
    vecs.push_back(mk(0, 3'b010, 3'b010, 24'hC2B1A5, 0, 3'b000, 1, 1, 2'd0, 8'hA5));
    vecs.push_back(mk(0, 3'b010, 3'b010, 24'hC2B1A5, 1, 3'b010, 1, 1, 2'd0, 8'hA5));
    vecs.push_back(mk(0, 3'b000, 3'b000, 24'hC2B1A5, 1, 3'b000, 1, 1, 2'd1, 8'hB1));
    vecs.push_back(mk(0, 3'b000, 3'b000, 24'hC2B1A5, 1, 3'b000, 0, 1, 2'd1, 8'hB1));
    // packet lock on channel 1 with a gap, channel 0 waiting
    vecs.push_back(mk(0, 3'b010, 3'b000, 24'h001055, 1, 3'b010, 0, 1, 2'd1, 8'hB1));
    vecs.push_back(mk(0, 3'b011, 3'b000, 24'h001155, 1, 3'b010, 1, 0, 2'd1, 8'h10));
    vecs.push_back(mk(0, 3'b001, 3'b000, 24'h001155, 1, 3'b000, 1, 0, 2'd1, 8'h11));
    vecs.push_back(mk(0, 3'b011, 3'b000, 24'h001255, 1, 3'b010, 0, 0, 2'd1, 8'h11));
    vecs.push_back(mk(0, 3'b011, 3'b010, 24'h001355, 1, 3'b010, 1, 0, 2'd1, 8'h12));
    vecs.push_back(mk(0, 3'b001, 3'b001, 24'h001355, 1, 3'b001, 1, 1, 2'd1, 8'h13));
    vecs.push_back(mk(0, 3'b000, 3'b000, 24'h001355, 1, 3'b000, 1, 1, 2'd0, 8'h55));
    // reset in the middle of a channel-2 packet
    vecs.push_back(mk(0, 3'b100, 3'b000, 24'h211355, 1, 3'b100, 0, 1, 2'd0, 8'h55));
    vecs.push_back(mk(0, 3'b101, 3'b000, 24'h221355, 1, 3'b100, 1, 0, 2'd2, 8'h21));
    vecs.push_back(mk(1, 3'b111, 3'b000, 24'h221355, 1, 3'b000, 1, 0, 2'd2, 8'h22));
    vecs.push_back(mk(0, 3'b111, 3'b000, 24'h221355, 1, 3'b001, 0, 0, 2'd0, 8'h00));
    vecs.push_back(mk(0, 3'b000, 3'b000, 24'h221355, 1, 3'b000, 1, 0, 2'd0, 8'h55));

    rst = 1'b1; v = 3'b111; l = 3'b111; d = 24'hC2B1A0; ordy = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; v = vecs[i].v; l = vecs[i].l; d = vecs[i].d; ordy = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i),  32'(if_rr.in_ready),  32'(vecs[i].rdy));
      chk($sformatf("v%0d out_valid", i), 32'(if_rr.out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d out_last", i),  32'(if_rr.out_last),  32'(vecs[i].ol));
      chk($sformatf("v%0d out_sel", i),   32'(if_rr.out_sel),   32'(vecs[i].sel));
      chk($sformatf("v%0d out_data", i),  32'(if_rr.out_data),  32'(vecs[i].od));
    end

    // fixed priority: channel 0 always wins while valid
    fv[0] = 3'b111; fv[1] = 3'b111; fv[2] = 3'b111; fv[3] = 3'b110; fv[4] = 3'b100; fv[5] = 3'b000;
    frdy[0] = 3'b001; frdy[1] = 3'b001; frdy[2] = 3'b001; frdy[3] = 3'b010; frdy[4] = 3'b100; frdy[5] = 3'b000;
    fsel[0] = 2'd0; fsel[1] = 2'd0; fsel[2] = 2'd0; fsel[3] = 2'd0; fsel[4] = 2'd1; fsel[5] = 2'd2;
    fov[0] = 1'b0; fov[1] = 1'b1; fov[2] = 1'b1; fov[3] = 1'b1; fov[4] = 1'b1; fov[5] = 1'b1;

    @(negedge clk);
    rst = 1'b1; v = 3'b000; l = 3'b111; d = 24'hC2B1A0; ordy = 1'b1;
    #1;
    chk("fp rst in_ready", 32'(if_fp.in_ready), 32'(3'b000));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rst = 1'b0; v = fv[k];
      #1;
      chk($sformatf("fp%0d in_ready", k),  32'(if_fp.in_ready),  32'(frdy[k]));
      chk($sformatf("fp%0d out_sel", k),   32'(if_fp.out_sel),   32'(fsel[k]));
      chk($sformatf("fp%0d out_valid", k), 32'(if_fp.out_valid), 32'(fov[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
